// File: rtl/host_bus_initiator.sv
// host_bus_initiator: host-side sequencer for the Xosera 8-bit async bus, one request per S+A+H+R+1 clks;
// req_ready_o stays low for the whole access. Define HOST_BUS_RDSYNC_EN for a 2-flop read-data synchronizer.
module host_bus_initiator #(
  parameter int SETUP_CLKS   = 2,
  parameter int ACTIVE_CLKS  = 8,
  parameter int HOLD_CLKS    = 2,
  parameter int RECOVER_CLKS = 4
) (
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rd_nwr_i,
  input  logic [3:0] req_reg_num_i,
  input  logic       req_bytesel_i,
  input  logic [7:0] req_data_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       bus_cs_n_o,
  output logic       bus_rd_nwr_o,
  output logic [3:0] bus_reg_num_o,
  output logic       bus_bytesel_o,
  output logic [7:0] bus_data_o,
  output logic       bus_data_oe_o,
  input  logic [7:0] bus_data_i
);

  localparam int MAX_SA   = (SETUP_CLKS > ACTIVE_CLKS) ? SETUP_CLKS : ACTIVE_CLKS;
  localparam int MAX_HR   = (HOLD_CLKS > RECOVER_CLKS) ? HOLD_CLKS : RECOVER_CLKS;
  localparam int MAX_CLKS = (MAX_SA > MAX_HR) ? MAX_SA : MAX_HR;
  localparam int CW       = $clog2(MAX_CLKS + 1);

  localparam logic [CW-1:0] S_LD = CW'(SETUP_CLKS - 1);
  localparam logic [CW-1:0] A_LD = CW'(ACTIVE_CLKS - 1);
  localparam logic [CW-1:0] H_LD = CW'(HOLD_CLKS - 1);
  localparam logic [CW-1:0] R_LD = CW'((RECOVER_CLKS > 0) ? RECOVER_CLKS - 1 : 0);

  generate
    if (SETUP_CLKS < 1 || ACTIVE_CLKS < 1 || HOLD_CLKS < 1 || RECOVER_CLKS < 0) begin : g_bad_timing
      $error("host_bus_initiator: illegal phase length parameter");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACTIVE,
    ST_HOLD,
    ST_RECOVER
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic [7:0]    rsp_dat_q, rsp_dat_d;
  logic          cs_n_q, cs_n_d;
  logic          rd_nwr_q, rd_nwr_d;
  logic [3:0]    reg_num_q, reg_num_d;
  logic          bytesel_q, bytesel_d;
  logic [7:0]    dat_q, dat_d;
  logic          oe_q, oe_d;
  logic [7:0]    cap_dat;

`ifdef HOST_BUS_RDSYNC_EN
  logic [7:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= bus_data_i;
      sync2_q <= sync1_q;
    end
  end

  assign cap_dat = sync2_q;

  generate
    if (ACTIVE_CLKS < 3) begin : g_bad_active
      $error("host_bus_initiator: ACTIVE_CLKS must be >= 3 with the read synchronizer");
    end
  endgenerate
`else
  assign cap_dat = bus_data_i;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    rsp_vld_d = 1'b0;
    rsp_dat_d = rsp_dat_q;
    cs_n_d    = cs_n_q;
    rd_nwr_d  = rd_nwr_q;
    reg_num_d = reg_num_q;
    bytesel_d = bytesel_q;
    dat_d     = dat_q;
    oe_d      = oe_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_d   = ST_SETUP;
          cnt_d     = S_LD;
          ready_d   = 1'b0;
          rd_nwr_d  = req_rd_nwr_i;
          reg_num_d = req_reg_num_i;
          bytesel_d = req_bytesel_i;
          dat_d     = req_data_i;
          oe_d      = ~req_rd_nwr_i;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_ACTIVE;
          cnt_d   = A_LD;
          cs_n_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_ACTIVE: begin
        // The last CS-low cycle is where the receiver's read data has settled.
        if (cnt_q == '0) begin
          state_d   = ST_HOLD;
          cnt_d     = H_LD;
          cs_n_d    = 1'b1;
          rsp_vld_d = 1'b1;
          if (rd_nwr_q) begin
            rsp_dat_d = cap_dat;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          oe_d     = 1'b0;
          rd_nwr_d = 1'b1;
          if (RECOVER_CLKS == 0) begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
          end else begin
            state_d = ST_RECOVER;
            cnt_d   = R_LD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        cs_n_d  = 1'b1;
        oe_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      rsp_vld_q <= 1'b0;
      rsp_dat_q <= 8'h00;
      cs_n_q    <= 1'b1;
      rd_nwr_q  <= 1'b1;
      reg_num_q <= 4'h0;
      bytesel_q <= 1'b0;
      dat_q     <= 8'h00;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_dat_q <= rsp_dat_d;
      cs_n_q    <= cs_n_d;
      rd_nwr_q  <= rd_nwr_d;
      reg_num_q <= reg_num_d;
      bytesel_q <= bytesel_d;
      dat_q     <= dat_d;
      oe_q      <= oe_d;
    end
  end

  assign req_ready_o   = ready_q;
  assign rsp_valid_o   = rsp_vld_q;
  assign rsp_data_o    = rsp_dat_q;
  assign bus_cs_n_o    = cs_n_q;
  assign bus_rd_nwr_o  = rd_nwr_q;
  assign bus_reg_num_o = reg_num_q;
  assign bus_bytesel_o = bytesel_q;
  assign bus_data_o    = dat_q;
  assign bus_data_oe_o = oe_q;

endmodule

// File: tb/tb_host_bus_initiator.sv
// Bench for host_bus_initiator: two instances (default timing and a minimal-timing one) checked
// cycle by cycle against expected waveforms derived from the phase lengths.
module tb_host_bus_initiator;

  localparam int S0 = 2, A0 = 8, H0 = 2, R0 = 4;
`ifdef HOST_BUS_RDSYNC_EN
  localparam int SYNC_D = 2;
  localparam int A1 = 3;
`else
  localparam int SYNC_D = 0;
  localparam int A1 = 1;
`endif
  localparam int S1 = 1, H1 = 1, R1 = 0;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       rd;
  logic [3:0] regn;
  logic       bs;
  logic [7:0] wdat;
  logic [7:0] pad;
  int         sel;

  logic       v0, v1;
  logic       r0_ready, r0_rsp_vld, r0_cs_n, r0_rd_nwr, r0_bs, r0_oe;
  logic [7:0] r0_rsp_dat, r0_dat;
  logic [3:0] r0_reg;
  logic       r1_ready, r1_rsp_vld, r1_cs_n, r1_rd_nwr, r1_bs, r1_oe;
  logic [7:0] r1_rsp_dat, r1_dat;
  logic [3:0] r1_reg;

  logic       o_ready, o_rsp_vld, o_cs_n, o_rd_nwr, o_bs, o_oe;
  logic [7:0] o_rsp_dat, o_dat;
  logic [3:0] o_reg;

  int         checks;
  int         failures;
  logic [7:0] exp_rsp [2];
  logic [7:0] plan [0:31];

  always #5 clk = ~clk;

  assign v0 = req_valid && (sel == 0);
  assign v1 = req_valid && (sel == 1);

  host_bus_initiator #(.SETUP_CLKS(S0), .ACTIVE_CLKS(A0), .HOLD_CLKS(H0), .RECOVER_CLKS(R0)) d0 (
    .clk(clk), .reset_n_i(reset_n), .req_valid_i(v0), .req_ready_o(r0_ready),
    .req_rd_nwr_i(rd), .req_reg_num_i(regn), .req_bytesel_i(bs), .req_data_i(wdat),
    .rsp_valid_o(r0_rsp_vld), .rsp_data_o(r0_rsp_dat), .bus_cs_n_o(r0_cs_n),
    .bus_rd_nwr_o(r0_rd_nwr), .bus_reg_num_o(r0_reg), .bus_bytesel_o(r0_bs),
    .bus_data_o(r0_dat), .bus_data_oe_o(r0_oe), .bus_data_i(pad)
  );

  host_bus_initiator #(.SETUP_CLKS(S1), .ACTIVE_CLKS(A1), .HOLD_CLKS(H1), .RECOVER_CLKS(R1)) d1 (
    .clk(clk), .reset_n_i(reset_n), .req_valid_i(v1), .req_ready_o(r1_ready),
    .req_rd_nwr_i(rd), .req_reg_num_i(regn), .req_bytesel_i(bs), .req_data_i(wdat),
    .rsp_valid_o(r1_rsp_vld), .rsp_data_o(r1_rsp_dat), .bus_cs_n_o(r1_cs_n),
    .bus_rd_nwr_o(r1_rd_nwr), .bus_reg_num_o(r1_reg), .bus_bytesel_o(r1_bs),
    .bus_data_o(r1_dat), .bus_data_oe_o(r1_oe), .bus_data_i(pad)
  );

  always_comb begin
    o_ready   = (sel == 1) ? r1_ready   : r0_ready;
    o_rsp_vld = (sel == 1) ? r1_rsp_vld : r0_rsp_vld;
    o_rsp_dat = (sel == 1) ? r1_rsp_dat : r0_rsp_dat;
    o_cs_n    = (sel == 1) ? r1_cs_n    : r0_cs_n;
    o_rd_nwr  = (sel == 1) ? r1_rd_nwr  : r0_rd_nwr;
    o_reg     = (sel == 1) ? r1_reg     : r0_reg;
    o_bs      = (sel == 1) ? r1_bs      : r0_bs;
    o_dat     = (sel == 1) ? r1_dat     : r0_dat;
    o_oe      = (sel == 1) ? r1_oe      : r0_oe;
  end

  task automatic chk1(input string tag, input int cyc, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut=%0d cyc=%0d observed=%b expected=%b", tag, sel, cyc, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input int cyc, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut=%0d cyc=%0d observed=%02h expected=%02h", tag, sel, cyc, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_ready"}, -1, o_ready, 1'b1);
    chk1({tag, "_rsp_vld"}, -1, o_rsp_vld, 1'b0);
    chk8({tag, "_rsp_dat"}, -1, o_rsp_dat, 8'h00);
    chk1({tag, "_cs_n"}, -1, o_cs_n, 1'b1);
    chk1({tag, "_rd_nwr"}, -1, o_rd_nwr, 1'b1);
    chk8({tag, "_reg"}, -1, {4'h0, o_reg}, 8'h00);
    chk1({tag, "_bs"}, -1, o_bs, 1'b0);
    chk8({tag, "_dat"}, -1, o_dat, 8'h00);
    chk1({tag, "_oe"}, -1, o_oe, 1'b0);
  endtask

  task automatic plan_random();
    for (int i = 0; i < 32; i++) plan[i] = 8'($urandom);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk1("idle_ready", i, o_ready, 1'b1);
      chk1("idle_cs_n", i, o_cs_n, 1'b1);
      chk1("idle_rsp_vld", i, o_rsp_vld, 1'b0);
    end
  endtask

  // Entered between edges of the handshake cycle (cycle 0); leaves at the negedge of the cycle
  // where ready returns. abort_at > 0 pulses reset during that cycle instead of completing.
  task automatic run_txn(input logic t_rd, input logic [3:0] t_reg, input logic t_bs,
                         input logic [7:0] t_dat, input bit hold, input int abort_at);
    int s, a, h, r, t;
    logic in_act, pre_rec;
    s = (sel == 1) ? S1 : S0;
    a = (sel == 1) ? A1 : A0;
    h = (sel == 1) ? H1 : H0;
    r = (sel == 1) ? R1 : R0;
    t = s + a + h + r + 1;
    chk1("ready_hs", 0, o_ready, 1'b1);
    req_valid = 1'b1;
    rd = t_rd; regn = t_reg; bs = t_bs; wdat = t_dat;
    pad = plan[0];
    for (int n = 1; n <= t; n++) begin
      @(posedge clk);
      #1;
      if (n == 1 && !hold) req_valid = 1'b0;
      rd = 1'($urandom); regn = 4'($urandom); bs = 1'($urandom); wdat = 8'($urandom);
      pad = plan[n];
      if (n == abort_at) begin
        #2 reset_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        exp_rsp[0] = 8'h00;
        exp_rsp[1] = 8'h00;
        req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
          @(negedge clk);
          chk1("post_rst_ready", i, o_ready, 1'b1);
          chk1("post_rst_cs_n", i, o_cs_n, 1'b1);
          chk1("post_rst_rsp_vld", i, o_rsp_vld, 1'b0);
        end
        return;
      end
      @(negedge clk);
      in_act  = (n >= s + 1) && (n <= s + a);
      pre_rec = (n <= s + a + h);
      if (n == s + a + 1 && t_rd) exp_rsp[sel] = plan[s + a - SYNC_D];
      chk1("cs_n", n, o_cs_n, !in_act);
      chk1("ready", n, o_ready, n == t);
      chk1("rsp_vld", n, o_rsp_vld, n == s + a + 1);
      chk1("rd_nwr", n, o_rd_nwr, pre_rec ? t_rd : 1'b1);
      chk1("oe", n, o_oe, pre_rec ? !t_rd : 1'b0);
      chk8("reg", n, {4'h0, o_reg}, {4'h0, t_reg});
      chk1("bs", n, o_bs, t_bs);
      chk8("wdat", n, o_dat, t_dat);
      chk8("rsp_dat", n, o_rsp_dat, exp_rsp[sel]);
    end
  endtask

  initial begin
    int nsel;
    bit hold;
    checks = 0; failures = 0;
    reset_n = 1'b0; req_valid = 1'b0;
    rd = 1'b0; regn = 4'h0; bs = 1'b0; wdat = 8'h00; pad = 8'h00; sel = 0;
    exp_rsp[0] = 8'h00; exp_rsp[1] = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst_d0");
    sel = 1; #1;
    chk_reset_vals("rst_d1");
    sel = 0;
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(2);

    // Directed write: reg 5, odd byte, 0x3C.
    plan_random();
    run_txn(1'b0, 4'h5, 1'b1, 8'h3C, 1'b0, 0);
    idle_cycles(1);

    // Directed read: pad 0xA5 while CS is low, 0xFF otherwise.
    for (int i = 0; i < 32; i++) plan[i] = (i >= 3 && i <= 10) ? 8'hA5 : 8'hFF;
    run_txn(1'b1, 4'hA, 1'b0, 8'h00, 1'b0, 0);
    idle_cycles(1);

    // Back-to-back with valid held: write then read.
    plan_random();
    run_txn(1'b0, 4'h3, 1'b0, 8'h5A, 1'b1, 0);
    plan_random();
    run_txn(1'b1, 4'hC, 1'b1, 8'h00, 1'b0, 0);
    idle_cycles(2);

    // Reset pulsed during cycle 6 of a write, then a normal write.
    plan_random();
    run_txn(1'b0, 4'h7, 1'b0, 8'h99, 1'b0, 6);
    plan_random();
    run_txn(1'b0, 4'h2, 1'b1, 8'hC3, 1'b0, 0);
    idle_cycles(1);

    // Pad pattern whose value two cycles before capture differs from the capture-cycle value.
    for (int i = 0; i < 32; i++) plan[i] = (i >= 3 && i <= 8) ? 8'h11 : ((i >= 9 && i <= 10) ? 8'h22 : 8'h00);
    run_txn(1'b1, 4'h1, 1'b0, 8'h00, 1'b0, 0);
    idle_cycles(1);

    // Minimal-timing instance, read of 0x81.
    sel = 1; #1;
    for (int i = 0; i < 32; i++) plan[i] = 8'h81;
    run_txn(1'b1, 4'h6, 1'b1, 8'h00, 1'b0, 0);
    idle_cycles(1);

    // Randomized traffic on both instances.
    nsel = int'($urandom_range(0, 1));
    for (int it = 0; it < 24; it++) begin
      sel = nsel; #1;
      nsel = int'($urandom_range(0, 1));
      hold = (nsel == sel) && ($urandom_range(0, 1) == 1);
      plan_random();
      run_txn(1'($urandom), 4'($urandom), 1'($urandom), 8'($urandom), hold, 0);
      if (!hold) idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
